// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse sequencer and its packet decoder.
package ps2_mouse_pkg;

  typedef enum logic [3:0] {
    ST_SEND_FF,
    ST_WAIT_ACK1,
    ST_WAIT_BAT,
    ST_WAIT_ID,
    ST_SEND_F4,
    ST_WAIT_ACK2,
    ST_STREAM0,
    ST_STREAM1,
    ST_STREAM2,
    ST_RETRY,
    ST_ERROR
  } state_t;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_ACK        = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK     = 8'hAA;
  localparam logic [7:0] PS2_MOUSE_ID   = 8'h00;

  // Bit positions inside the first (header) byte of a stream packet.
  localparam int BIT_LEFT   = 0;
  localparam int BIT_RIGHT  = 1;
  localparam int BIT_MIDDLE = 2;
  localparam int BIT_SYNC   = 3;
  localparam int BIT_X_SIGN = 4;
  localparam int BIT_Y_SIGN = 5;
  localparam int BIT_X_OVF  = 6;
  localparam int BIT_Y_OVF  = 7;

  function automatic logic [11:0] clamp_coord(input logic signed [11:0] v,
                                              input logic [11:0] hi);
    if (v < 0) return '0;
    if (v > $signed(hi)) return hi;
    return v;
  endfunction

endpackage

// File: rtl/ps2_mouse_packet_decoder.sv
// Holds the packet header/byte1 registers and turns committed packets into
// clamped screen coordinates and button state.
module ps2_mouse_packet_decoder
  import ps2_mouse_pkg::*;
#(
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       load_byte0,
  input  logic       load_byte1,
  input  logic       commit,
  input  logic       recenter,
  output logic [9:0] x_position,
  output logic [8:0] y_position,
  output logic       left_button,
  output logic       right_button,
  output logic       packet_valid
);

  logic [7:0]         byte0_q;
  logic [7:0]         byte1_q;
  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic signed [11:0] x_sum;
  logic signed [11:0] y_sum;
  logic               unused_head;

  // byte2 is consumed straight off the bus on the commit strobe.
  assign dx    = byte0_q[BIT_X_OVF] ? '0 : {{4{byte0_q[BIT_X_SIGN]}}, byte1_q};
  assign dy    = byte0_q[BIT_Y_OVF] ? '0 : {{4{byte0_q[BIT_Y_SIGN]}}, data};
  assign x_sum = $signed({2'b00, x_position}) + dx;
  assign y_sum = $signed({3'b000, y_position}) - dy;

  assign unused_head = ^{byte0_q[BIT_MIDDLE], byte0_q[BIT_SYNC]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte0_q      <= '0;
      byte1_q      <= '0;
      x_position   <= 10'(X_INIT);
      y_position   <= 9'(Y_INIT);
      left_button  <= 1'b0;
      right_button <= 1'b0;
      packet_valid <= 1'b0;
    end else begin
      packet_valid <= commit;
      if (load_byte0) byte0_q <= data;
      if (load_byte1) byte1_q <= data;
      if (recenter) begin
        x_position <= 10'(X_INIT);
        y_position <= 9'(Y_INIT);
      end else if (commit) begin
        x_position   <= 10'(clamp_coord(x_sum, 12'(X_MAX)));
        y_position   <= 9'(clamp_coord(y_sum, 12'(Y_MAX)));
        left_button  <= byte0_q[BIT_LEFT];
        right_button <= byte0_q[BIT_RIGHT];
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_sequencer.sv
// Drives PS/2 mouse initialisation (reset, self-test, enable streaming) with
// retries, then assembles stream packets into cursor position and buttons.
module ps2_mouse_sequencer
  import ps2_mouse_pkg::*;
#(
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int X_INIT       = 320,
  parameter int Y_INIT       = 240,
  parameter int RESP_TIMEOUT = 50_000_000,
  parameter int PKT_GAP      = 1_000_000,
  parameter int MAX_RETRY    = 3
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  output logic [7:0] the_command,
  output logic       send_command,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [9:0] x_position,
  output logic [8:0] y_position,
  output logic       left_button,
  output logic       right_button,
  output logic       packet_valid,
  output logic       init_done,
  output logic       init_error
);

  localparam int TMAX = (RESP_TIMEOUT > PKT_GAP) ? RESP_TIMEOUT : PKT_GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(MAX_RETRY + 1);

  state_t          state;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   retry;
  logic [7:0]      wait_byte;
  state_t          wait_next;
  logic            resp_expired;
  logic            gap_expired;
  logic            hot_plug;
  logic            load_byte0;
  logic            load_byte1;
  logic            commit;

  assign resp_expired = (timer == TW'(RESP_TIMEOUT - 1));
  assign gap_expired  = (timer == TW'(PKT_GAP - 1));

  // 0xAA has the sync bit set, so the hot-plug check must win over byte0.
  assign hot_plug   = (state == ST_STREAM0) && received_data_en && (received_data == PS2_BAT_OK);
  assign load_byte0 = (state == ST_STREAM0) && received_data_en && !hot_plug
                      && received_data[BIT_SYNC];
  assign load_byte1 = (state == ST_STREAM1) && received_data_en;
  assign commit     = (state == ST_STREAM2) && received_data_en;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    wait_byte = PS2_ACK;
    wait_next = ST_WAIT_BAT;
    case (state)
      ST_WAIT_BAT: begin
        wait_byte = PS2_BAT_OK;
        wait_next = ST_WAIT_ID;
      end
      ST_WAIT_ID: begin
        wait_byte = PS2_MOUSE_ID;
        wait_next = ST_SEND_F4;
      end
      ST_WAIT_ACK2: begin
        wait_byte = PS2_ACK;
        wait_next = ST_STREAM0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_SEND_FF;
      timer        <= '0;
      retry        <= '0;
      the_command  <= PS2_CMD_RESET;
      send_command <= 1'b0;
      init_done    <= 1'b0;
      init_error   <= 1'b0;
    end else begin
      case (state)
        ST_SEND_FF, ST_SEND_F4: begin
          timer <= '0;
          // Raise one cycle after entry so the_command is already settled.
          if (!send_command) begin
            send_command <= 1'b1;
          end else if (command_was_sent) begin
            send_command <= 1'b0;
            state        <= (state == ST_SEND_FF) ? ST_WAIT_ACK1 : ST_WAIT_ACK2;
          end else if (error_communication_timed_out) begin
            send_command <= 1'b0;
            state        <= ST_RETRY;
          end
        end

        ST_WAIT_ACK1, ST_WAIT_BAT, ST_WAIT_ID, ST_WAIT_ACK2: begin
          if (received_data_en) begin
            timer <= '0;
            if (received_data == wait_byte) begin
              state <= wait_next;
              if (wait_next == ST_SEND_F4) the_command <= PS2_CMD_ENABLE;
              if (wait_next == ST_STREAM0) init_done <= 1'b1;
            end else begin
              state <= ST_RETRY;
            end
          end else if (resp_expired) begin
            timer <= '0;
            state <= ST_RETRY;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        ST_RETRY: begin
          retry <= retry + RW'(1);
          if (retry + RW'(1) == RW'(MAX_RETRY)) begin
            state      <= ST_ERROR;
            init_error <= 1'b1;
          end else begin
            state       <= ST_SEND_FF;
            the_command <= PS2_CMD_RESET;
          end
        end

        ST_STREAM0: begin
          timer <= '0;
          if (hot_plug) begin
            state       <= ST_SEND_F4;
            retry       <= '0;
            the_command <= PS2_CMD_ENABLE;
            init_done   <= 1'b0;
          end else if (load_byte0) begin
            state <= ST_STREAM1;
          end
        end

        ST_STREAM1, ST_STREAM2: begin
          if (received_data_en) begin
            timer <= '0;
            state <= (state == ST_STREAM1) ? ST_STREAM2 : ST_STREAM0;
          end else if (gap_expired) begin
            timer <= '0;
            state <= ST_STREAM0;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        ST_ERROR: ;

        default: begin
          timer <= '0;
          state <= ST_SEND_FF;
        end
      endcase
    end
  end

  ps2_mouse_packet_decoder #(
    .X_MAX  (X_MAX),
    .Y_MAX  (Y_MAX),
    .X_INIT (X_INIT),
    .Y_INIT (Y_INIT)
  ) u_decoder (
    .clk          (CLOCK_50),
    .rst_n        (resetn),
    .data         (received_data),
    .load_byte0   (load_byte0),
    .load_byte1   (load_byte1),
    .commit       (commit),
    .recenter     (hot_plug),
    .x_position   (x_position),
    .y_position   (y_position),
    .left_button  (left_button),
    .right_button (right_button),
    .packet_valid (packet_valid)
  );

endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
// Scoreboard bench: a mouse-side driver issues init responses and packets, a
// reference model predicts each packet's outcome, a monitor checks packet_valid.
module tb_ps2_mouse_sequencer;

  localparam int RT = 200;
  localparam int PG = 60;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] the_command;
  logic       send_command;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic [7:0] received_data;
  logic       received_data_en;
  logic [9:0] x_position;
  logic [8:0] y_position;
  logic       left_button;
  logic       right_button;
  logic       packet_valid;
  logic       init_done;
  logic       init_error;

  always #5 clk = ~clk;

  ps2_mouse_sequencer #(
    .RESP_TIMEOUT (RT),
    .PKT_GAP      (PG)
  ) dut (
    .CLOCK_50                      (clk),
    .resetn                        (resetn),
    .the_command                   (the_command),
    .send_command                  (send_command),
    .command_was_sent              (command_was_sent),
    .error_communication_timed_out (error_communication_timed_out),
    .received_data                 (received_data),
    .received_data_en              (received_data_en),
    .x_position                    (x_position),
    .y_position                    (y_position),
    .left_button                   (left_button),
    .right_button                  (right_button),
    .packet_valid                  (packet_valid),
    .init_done                     (init_done),
    .init_error                    (init_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: cursor as plain integers, updated by the packet rules.
  typedef struct {int x; int y; int l; int r;} exp_t;
  exp_t sb_q[$];
  int   mx = 320;
  int   my = 240;
  int   ml = 0;
  int   mr = 0;

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // Monitor: every packet_valid pulse must match the oldest prediction.
  always @(posedge clk) begin
    #1;
    if (resetn === 1'b1 && packet_valid === 1'b1) begin
      check("packet_expected", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("pkt_x", x_position, e.x);
        check("pkt_y", y_position, e.y);
        check("pkt_left", left_button, e.l);
        check("pkt_right", right_button, e.r);
      end
    end
  end

  // Counts command requests and checks the command is settled before the request.
  logic       prev_send = 1'b0;
  logic [7:0] prev_cmd = 8'h00;
  int         ff_sends = 0;
  int         f4_sends = 0;
  always @(posedge clk) begin
    #1;
    if (resetn !== 1'b1) begin
      prev_send = 1'b0;
      prev_cmd  = the_command;
    end else begin
      if (send_command && !prev_send) begin
        check("cmd_stable_before_send", the_command, prev_cmd);
        if (the_command == 8'hFF) ff_sends++;
        else if (the_command == 8'hF4) f4_sends++;
      end
      prev_send = send_command;
      prev_cmd  = the_command;
    end
  end

  // mode: 0 = accepted, 1 = timed out, 2 = both pulses together.
  task automatic serve_cmd(input logic [7:0] exp_cmd, input int mode, output int waited);
    waited = 0;
    while (send_command !== 1'b1 && waited < RT * 3) begin
      @(negedge clk);
      waited++;
    end
    check("send_seen", send_command, 1);
    if (send_command !== 1'b1) return;
    check("cmd_value", the_command, exp_cmd);
    repeat ($urandom_range(3, 1)) @(negedge clk);
    check("send_held", send_command, 1);
    command_was_sent = (mode != 1);
    error_communication_timed_out = (mode != 0);
    @(negedge clk);
    command_was_sent = 1'b0;
    error_communication_timed_out = 1'b0;
    check("send_dropped", send_command, 0);
  endtask

  task automatic put_byte(input logic [7:0] b);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
    repeat ($urandom_range(2, 0)) @(negedge clk);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int   dx;
    int   dy;
    exp_t e;
    put_byte(b0);
    put_byte(b1);
    dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    mx = clampi(mx + dx, 639);
    my = clampi(my - dy, 479);
    ml = int'(b0[0]);
    mr = int'(b0[1]);
    e = '{x: mx, y: my, l: ml, r: mr};
    sb_q.push_back(e);
    put_byte(b2);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_x"}, x_position, 320);
    check({tag, "_y"}, y_position, 240);
    check({tag, "_left"}, left_button, 0);
    check({tag, "_right"}, right_button, 0);
    check({tag, "_pvalid"}, packet_valid, 0);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_init_error"}, init_error, 0);
    check({tag, "_send"}, send_command, 0);
    check({tag, "_cmd"}, the_command, 8'hFF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [7:0] b0;
    resetn = 1'b0;
    command_was_sent = 1'b0;
    error_communication_timed_out = 1'b0;
    received_data = 8'h00;
    received_data_en = 1'b0;
    #23;
    check_idle_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Nominal initialisation.
    serve_cmd(8'hFF, 0, w);
    put_byte(8'hFA);
    put_byte(8'hAA);
    put_byte(8'h00);
    serve_cmd(8'hF4, 0, w);
    put_byte(8'hFA);
    check("init_done_after_init", init_done, 1);
    check("init_error_after_init", init_error, 0);
    check("ff_send_count", ff_sends, 1);
    check("f4_send_count", f4_sends, 1);

    // Basic packet, then clamping on both axes.
    send_packet(8'h09, 8'h0A, 8'h05);
    send_packet(8'h18, 8'h00, 8'h00);
    send_packet(8'h18, 8'h00, 8'h00);
    repeat (5) send_packet(8'h08, 8'h7F, 8'h00);
    repeat (2) send_packet(8'h08, 8'hFF, 8'h00);
    repeat (2) send_packet(8'h28, 8'h00, 8'h00);
    repeat (5) send_packet(8'h0A, 8'h00, 8'h7F);

    // Overflow packet, then a stray non-sync byte that must be discarded.
    send_packet(8'h48, 8'h50, 8'h10);
    put_byte(8'h00);
    send_packet(8'h09, 8'h01, 8'h01);

    // Randomized packets (header 0xAA would be a hot-plug, so avoid it).
    for (int i = 0; i < 30; i++) begin
      b0 = 8'($urandom_range(255, 0)) | 8'h08;
      if (b0 == 8'hAA) b0 = 8'hAB;
      send_packet(b0, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
    end

    // Inter-byte gap drops the partial packet.
    put_byte(8'h0B);
    put_byte(8'h40);
    repeat (PG + 5) @(negedge clk);
    send_packet(8'h0A, 8'h03, 8'h04);

    // Hot-plug self-test in STREAM0: re-enable and recentre.
    put_byte(8'hAA);
    mx = 320;
    my = 240;
    check("hotplug_init_done_drop", init_done, 0);
    serve_cmd(8'hF4, 2, w);
    put_byte(8'hFA);
    check("hotplug_init_done", init_done, 1);
    check("hotplug_x", x_position, 320);
    check("hotplug_y", y_position, 240);
    send_packet(8'h09, 8'h0A, 8'h05);
    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    // Asynchronous reset mid-packet.
    put_byte(8'h09);
    put_byte(8'h20);
    #2;
    resetn = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    mx = 320;
    my = 240;
    @(negedge clk);
    resetn = 1'b1;

    // Timeout, wrong byte and failed send exhaust the retries.
    serve_cmd(8'hFF, 0, w);
    serve_cmd(8'hFF, 0, w);
    check("resp_timeout_delay_ok", (w >= RT - 1) && (w <= RT + 5), 1);
    put_byte(8'h55);
    serve_cmd(8'hFF, 1, w);
    repeat (5) @(negedge clk);
    check("error_flag", init_error, 1);
    check("error_init_done", init_done, 0);
    put_byte(8'hFA);
    repeat (RT * 2) @(negedge clk);
    check("error_sticky", init_error, 1);
    check("error_no_send", send_command, 0);
    check("error_no_packet_pending", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_sequencer.md
Name: ps2_mouse_sequencer

Overview:
Sits above PS2_Controller (instantiated with INITIALIZE_MOUSE=0) and owns its command and receive handshakes.
- Initialisation: reset (0xFF), self-test check, enable streaming (0xF4), with timeouts and bounded retries.
- Streaming: assembles 3-byte PS/2 mouse packets into clamped screen coordinates (640x480) and button state for the benchmark UI.

Parameters:
X_MAX, 639, largest x_position value
Y_MAX, 479, largest y_position value
X_INIT, 320, x_position after reset or re-init
Y_INIT, 240, y_position after reset or re-init
RESP_TIMEOUT, 50_000_000, cycles to wait for any init response byte (1 s at 50 MHz)
PKT_GAP, 1_000_000, maximum cycles between bytes of one packet (20 ms)
MAX_RETRY, 3, init attempts before entering ERROR

Ports:
CLOCK_50  in  1  system clock, 50 MHz
resetn  in  1  asynchronous active-low reset
the_command  out  8  command byte to PS2_Controller
send_command  out  1  command request to PS2_Controller
command_was_sent  in  1  command-accepted pulse
error_communication_timed_out  in  1  command-failure pulse
received_data  in  8  received byte
received_data_en  in  1  one-cycle received-byte strobe
x_position  out  10  cursor x, 0..X_MAX
y_position  out  9  cursor y, 0..Y_MAX; 0 is the top of the screen
left_button  out  1  byte0[0] of the last accepted packet
right_button  out  1  byte0[1] of the last accepted packet
packet_valid  out  1  one-cycle pulse per accepted packet
init_done  out  1  high while in streaming states
init_error  out  1  high in ERROR; sticky until reset

Behaviour:
- Reset: all registers clear asynchronously on resetn=0, mid-operation included.
  - State=SEND_FF, retry=0, the_command=0xFF, send_command=0.
  - x=X_INIT, y=Y_INIT; buttons, packet_valid, init_done, init_error all 0.
- Command handshake (SEND_FF, SEND_F4):
  - the_command is stable before send_command rises.
  - send_command is held high until command_was_sent or error_communication_timed_out is sampled high, then dropped the same edge.
  - After dropping, send_command stays low for at least 1 cycle.
  - Timed-out send -> RETRY.
- States and transitions:
  - SEND_FF: sent -> WAIT_ACK1.
  - WAIT_ACK1: byte 0xFA -> WAIT_BAT.
  - WAIT_BAT: byte 0xAA -> WAIT_ID.
  - WAIT_ID: byte 0x00 -> SEND_F4.
  - SEND_F4: sent -> WAIT_ACK2.
  - WAIT_ACK2: byte 0xFA -> STREAM0.
  - In any WAIT_*: an unexpected byte, or RESP_TIMEOUT cycles with no received_data_en, -> RETRY.
  - The response timer clears on every state entry.
  - RETRY: retry+1. If the new value equals MAX_RETRY -> ERROR, else -> SEND_FF. Takes 1 cycle.
  - ERROR: terminal; ignores all inputs.
  - STREAM0: byte with bit3=1 -> latch as byte0, go to STREAM1. bit3=0 -> discard, stay (resync).
  - STREAM1: latch byte1 -> STREAM2.
  - STREAM2: latch byte2, commit, -> STREAM0.
  - In STREAM1/STREAM2, PKT_GAP cycles with no byte -> STREAM0 with the partial packet dropped.
  - A byte 0xAA in STREAM0 (hot-plug self-test) -> SEND_F4 after retry is cleared; init_done drops.
- Commit, registered; outputs update the cycle after the byte2 strobe and packet_valid pulses that same cycle:
  - dx = signed 9-bit {byte0[4], byte1}; dy = signed 9-bit {byte0[5], byte2}.
  - If byte0[6] (X overflow) is set, dx is treated as 0. If byte0[7] (Y overflow) is set, dy is treated as 0.
  - x_next = x + dx, computed in 12-bit signed, clamped to [0, X_MAX].
  - y_next = y - dy (PS/2 +dy means up), computed in 12-bit signed, clamped to [0, Y_MAX].
  - Buttons update on every commit, overflow packets included.
- Boundary cases:
  - received_data_en during SEND_*: ignored.
  - command_was_sent and timeout sampled in the same cycle: treated as sent.
  - Position saturates at the edges; it never wraps.
  - init_done=1 exactly in STREAM0/1/2.

Decomposition:
- Shared package ps2_mouse_pkg holds:
  - State enum.
  - Byte constants PS2_CMD_RESET=0xFF, PS2_CMD_ENABLE=0xF4, PS2_ACK=0xFA, PS2_BAT_OK=0xAA, PS2_MOUSE_ID=0x00.
  - Packet bit indices.
- One sub-module, ps2_mouse_packet_decoder: the byte0/1/2 registers plus the delta/clamp arithmetic. It takes a commit pulse and the three bytes and returns x, y, buttons.
- The FSM, timers and retry counter stay in the top module.

Test Plan:
- Nominal init: responses FA, AA, 00, then FA after 0xF4 is sent -> init_done=1, one send_command pulse each for 0xFF and 0xF4, init_error=0.
- Packet commit: packet 0x09, 0x0A, 0x05 from x=320, y=240 -> x=330, y=235, left_button=1, one packet_valid pulse.
- Clamping: packet 0x18, 0x00, 0x00 (dx=-256) twice from x=320 -> x=64, then x=0. Packet 0x08, 0xFF, 0x00 repeated from x=630 -> x=639.
- Overflow and resync:
  - 0x48, 0x50, 0x10 -> x unchanged, y=224, buttons updated.
  - A stray 0x00 byte in STREAM0 is discarded with no packet_valid.
- Timeouts:
  - No response after 0xFF acknowledged -> retry after RESP_TIMEOUT cycles.
  - Third failure -> init_error=1, state stays ERROR.
  - Gap > PKT_GAP after byte1 -> next 3 bytes form a fresh packet.
- Reset and hot-plug:
  - resetn low mid-packet -> outputs reach reset values immediately, without waiting for a clock edge.
  - 0xAA received in STREAM0 -> 0xF4 resent, then FA -> init_done=1 again.
